// File: rtl/elastic_config_loader_if.sv
// rtl/elastic_config_loader_if.sv - valid/stop configuration record stream between record source and loader
interface elastic_config_loader_if #(
    parameter int PE_ID_WIDTH             = 5,
    parameter int CONTEXT_SIZE_BIT_LENGTH = 3,
    parameter int INPUT_NUM_BIT_LENGTH    = 3,
    parameter int NEIGHBOR_PE_NUM         = 4,
    parameter int OPERATION_BIT_LENGTH    = 4,
    parameter int DATA_WIDTH              = 32
);
    logic                               cfg_valid;
    logic                               cfg_stop;
    logic [PE_ID_WIDTH-1:0]             cfg_pe_id;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cfg_context_index;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_index_1;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_index_2;
    logic [NEIGHBOR_PE_NUM-1:0]         cfg_output_mask;
    logic [OPERATION_BIT_LENGTH-1:0]    cfg_op;
    logic [DATA_WIDTH-1:0]              cfg_const_data;

    modport master (
        output cfg_valid, cfg_pe_id, cfg_context_index, cfg_input_index_1,
               cfg_input_index_2, cfg_output_mask, cfg_op, cfg_const_data,
        input  cfg_stop
    );

    modport slave (
        input  cfg_valid, cfg_pe_id, cfg_context_index, cfg_input_index_1,
               cfg_input_index_2, cfg_output_mask, cfg_op, cfg_const_data,
        output cfg_stop
    );
endinterface

// File: rtl/elastic_config_loader.sv
// rtl/elastic_config_loader.sv - record stream to per-PE config writes plus start_exec; optional CONFIG_LOADER_BROADCAST_EN
module elastic_config_loader #(
    parameter int PE_NUM                  = 16,
    parameter int PE_ID_WIDTH             = 5,
    parameter int CONTEXT_SIZE            = 8,
    parameter int CONTEXT_SIZE_BIT_LENGTH = 3,
    parameter int INPUT_NUM_BIT_LENGTH    = 3,
    parameter int NEIGHBOR_PE_NUM         = 4,
    parameter int OPERATION_BIT_LENGTH    = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int COUNT_WIDTH             = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               load_start_i,
    input  logic                               load_abort_i,
    input  logic [COUNT_WIDTH-1:0]             load_entry_count_i,
    elastic_config_loader_if.slave             cfg_if,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1_o,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2_o,
    output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index_o,
    output logic [OPERATION_BIT_LENGTH-1:0]    config_op_o,
    output logic [DATA_WIDTH-1:0]              config_const_data_o,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index_o,
    output logic [PE_NUM-1:0]                  write_config_data_o,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id_o,
    output logic                               start_exec_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               error_o
);
    typedef enum logic [1:0] {IDLE, LOAD, START} state_t;

    state_t                               state_q;
    logic [COUNT_WIDTH-1:0]               remaining_q, remaining_d;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0]   max_id_q, max_id_d, map_max_q;
    logic [INPUT_NUM_BIT_LENGTH-1:0]      in1_q, in2_q;
    logic [NEIGHBOR_PE_NUM-1:0]           out_mask_q;
    logic [OPERATION_BIT_LENGTH-1:0]      op_q;
    logic [DATA_WIDTH-1:0]                const_q;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0]   ctx_q;
    logic [PE_NUM-1:0]                    wr_q;
    logic                                 start_q, done_q, error_q;

    logic              accept, pe_ok, ctx_ok, bcast, drop;
    logic [PE_NUM-1:0] wr_mask;

    // Stop depends only on state so the source never sees a path from its own valid.
    assign cfg_if.cfg_stop = (state_q != LOAD);
    assign accept          = (state_q == LOAD) && cfg_if.cfg_valid;
    assign pe_ok           = int'(cfg_if.cfg_pe_id) < PE_NUM;
    assign ctx_ok          = int'(cfg_if.cfg_context_index) < CONTEXT_SIZE;
`ifdef CONFIG_LOADER_BROADCAST_EN
    assign bcast           = &cfg_if.cfg_pe_id;
`else
    assign bcast           = 1'b0;
`endif
    assign drop            = !ctx_ok || !(pe_ok || bcast);
    assign wr_mask         = bcast ? {PE_NUM{1'b1}} : (PE_NUM'(1) << cfg_if.cfg_pe_id);
    assign remaining_d     = remaining_q - COUNT_WIDTH'(1);
    assign max_id_d        = (!drop && (cfg_if.cfg_context_index > max_id_q)) ?
                             cfg_if.cfg_context_index : max_id_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            max_id_q    <= '0;
            map_max_q   <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            out_mask_q  <= '0;
            op_q        <= '0;
            const_q     <= '0;
            ctx_q       <= '0;
            wr_q        <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_q    <= '0;
            start_q <= 1'b0;
            if (accept) begin
                in1_q       <= cfg_if.cfg_input_index_1;
                in2_q       <= cfg_if.cfg_input_index_2;
                out_mask_q  <= cfg_if.cfg_output_mask;
                op_q        <= cfg_if.cfg_op;
                const_q     <= cfg_if.cfg_const_data;
                ctx_q       <= cfg_if.cfg_context_index;
                remaining_q <= remaining_d;
                max_id_q    <= max_id_d;
                if (drop) error_q <= 1'b1;
                else      wr_q    <= wr_mask;
            end
            case (state_q)
                IDLE: begin
                    if (load_start_i) begin
                        remaining_q <= load_entry_count_i;
                        max_id_q    <= '0;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        state_q     <= (load_entry_count_i != '0) ? LOAD : START;
                    end
                end
                LOAD: begin
                    if (load_abort_i) begin
                        state_q <= IDLE;
                    end else if (accept && remaining_q == COUNT_WIDTH'(1)) begin
                        // Start fires on the same edge as the final write.
                        state_q   <= START;
                        start_q   <= 1'b1;
                        map_max_q <= max_id_d;
                    end
                end
                START: begin
                    if (load_abort_i) begin
                        state_q <= IDLE;
                    end else if (!start_q) begin
                        start_q   <= 1'b1;
                        map_max_q <= max_id_q;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign config_input_PE_index_1_o = in1_q;
    assign config_input_PE_index_2_o = in2_q;
    assign config_output_PE_index_o  = out_mask_q;
    assign config_op_o               = op_q;
    assign config_const_data_o       = const_q;
    assign config_index_o            = ctx_q;
    assign write_config_data_o       = wr_q;
    assign mapping_context_max_id_o  = map_max_q;
    assign start_exec_o              = start_q;
    assign busy_o                    = (state_q != IDLE);
    assign done_o                    = done_q;
    assign error_o                   = error_q;
endmodule

// File: tb/tb_elastic_config_loader.sv
// tb/tb_elastic_config_loader.sv - scoreboard bench for elastic_config_loader
module tb_elastic_config_loader;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_start, load_abort;
    logic [15:0] load_entry_count;
    logic [2:0]  in1, in2, cidx, max_id;
    logic [3:0]  out_pe, op;
    logic [31:0] cdata;
    logic [15:0] wr;
    logic        start_exec, busy, done, error;

    always #5 clk = ~clk;

    elastic_config_loader_if cfg_if ();

    elastic_config_loader dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .load_start_i              (load_start),
        .load_abort_i              (load_abort),
        .load_entry_count_i        (load_entry_count),
        .cfg_if                    (cfg_if.slave),
        .config_input_PE_index_1_o (in1),
        .config_input_PE_index_2_o (in2),
        .config_output_PE_index_o  (out_pe),
        .config_op_o               (op),
        .config_const_data_o       (cdata),
        .config_index_o            (cidx),
        .write_config_data_o       (wr),
        .mapping_context_max_id_o  (max_id),
        .start_exec_o              (start_exec),
        .busy_o                    (busy),
        .done_o                    (done),
        .error_o                   (error)
    );

    typedef struct {
        logic [15:0] wr;
        logic        st;
        logic [2:0]  mx;
        logic [3:0]  op;
        logic [31:0] cd;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

`ifdef CONFIG_LOADER_BROADCAST_EN
    localparam logic [15:0] BC_WR  = 16'hFFFF;
    localparam logic        BC_ERR = 1'b0;
    localparam int          BC_MAX = 4;
`else
    localparam logic [15:0] BC_WR  = 16'h0000;
    localparam logic        BC_ERR = 1'b1;
    localparam int          BC_MAX = 0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every write or start pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && (wr !== 16'h0 || start_exec !== 1'b0)) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {47'h0, start_exec, wr}, 64'h0);
            end else begin
                mon_e = q.pop_front();
                chk("write_mask", 64'(wr), 64'(mon_e.wr));
                chk("start_exec", 64'(start_exec), 64'(mon_e.st));
                if (mon_e.st) chk("max_id", 64'(max_id), 64'(mon_e.mx));
                if (mon_e.wr != 16'h0) begin
                    chk("config_op", 64'(op), 64'(mon_e.op));
                    chk("config_const", 64'(cdata), 64'(mon_e.cd));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_session(input int count);
        load_start       = 1'b1;
        load_entry_count = 16'(count);
        tick();
        load_start       = 1'b0;
    endtask

    task automatic send(input int pe, input int ctx, input int opc, input logic [31:0] cd,
                        input logic [15:0] exp_wr, input bit last, input int exp_max);
        int   n;
        exp_t e;
        n = 0;
        while (cfg_if.cfg_stop !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("ready_timeout", 64'(cfg_if.cfg_stop), 64'h0);
        cfg_if.cfg_pe_id         = 5'(pe);
        cfg_if.cfg_context_index = 3'(ctx);
        cfg_if.cfg_input_index_1 = 3'(pe);
        cfg_if.cfg_input_index_2 = 3'(ctx);
        cfg_if.cfg_output_mask   = 4'(opc);
        cfg_if.cfg_op            = 4'(opc);
        cfg_if.cfg_const_data    = cd;
        if (exp_wr != 16'h0 || last) begin
            e.wr = exp_wr;
            e.st = last;
            e.mx = 3'(exp_max);
            e.op = 4'(opc);
            e.cd = cd;
            q.push_back(e);
        end
        cfg_if.cfg_valid = 1'b1;
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic end_session(input logic exp_err, input int exp_max);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("done", 64'(done), 64'h1);
        chk("error", 64'(error), 64'(exp_err));
        chk("mapping_max", 64'(max_id), 64'(exp_max));
        chk("busy_idle", 64'(busy), 64'h0);
        chk("stop_idle", 64'(cfg_if.cfg_stop), 64'h1);
        chk("events_drained", 64'(q.size()), 64'h0);
    endtask

    initial begin
        reset_n          = 1'b0;
        load_start       = 1'b0;
        load_abort       = 1'b0;
        load_entry_count = 16'h0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_pe_id = '0;
        cfg_if.cfg_context_index = '0;
        cfg_if.cfg_input_index_1 = '0;
        cfg_if.cfg_input_index_2 = '0;
        cfg_if.cfg_output_mask   = '0;
        cfg_if.cfg_op            = '0;
        cfg_if.cfg_const_data    = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_stop", 64'(cfg_if.cfg_stop), 64'h1);
        chk("rst_write", 64'(wr), 64'h0);
        chk("rst_start", 64'(start_exec), 64'h0);
        chk("rst_flags", {61'h0, busy, done, error}, 64'h0);
        chk("rst_fields", {in1, in2, out_pe, op, cidx, max_id}, 64'h0);
        chk("rst_const", 64'(cdata), 64'h0);

        // Three back-to-back records, start with the last write.
        begin_session(3);
        chk("stop_after_start", 64'(cfg_if.cfg_stop), 64'h0);
        send(0,  0, 1, 32'h1111_0000, 16'h0001, 1'b0, 0);
        send(5,  2, 2, 32'h2222_0005, 16'h0020, 1'b0, 2);
        send(15, 1, 3, 32'h3333_000F, 16'h8000, 1'b1, 2);
        end_session(1'b0, 2);

        // Valid toggling; a stray load_start mid-session is ignored.
        begin_session(4);
        send(1, 3, 4, 32'hA0, 16'h0002, 1'b0, 3);
        load_start = 1'b1; load_entry_count = 16'd100; tick(); load_start = 1'b0;
        send(2, 6, 5, 32'hA1, 16'h0004, 1'b0, 6);
        tick();
        send(3, 4, 6, 32'hA2, 16'h0008, 1'b0, 6);
        tick();
        send(4, 5, 7, 32'hA3, 16'h0010, 1'b1, 6);
        end_session(1'b0, 6);

        // Out-of-range PE ids: dropped, still counted.
        begin_session(2);
        send(16, 9, 8, 32'hB0, 16'h0000, 1'b0, 0);
        send(20, 7, 9, 32'hB1, 16'h0000, 1'b1, 0);
        end_session(1'b1, 0);

        // Abort after two of five records.
        begin_session(5);
        send(1, 0, 10, 32'hC0, 16'h0002, 1'b0, 0);
        send(2, 1, 11, 32'hC1, 16'h0004, 1'b0, 1);
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        chk("abort_stop", 64'(cfg_if.cfg_stop), 64'h1);
        chk("abort_busy", 64'(busy), 64'h0);
        repeat (4) tick();
        chk("abort_done", 64'(done), 64'h0);
        chk("abort_drained", 64'(q.size()), 64'h0);

        // Zero-count session: start two cycles after load_start.
        begin
            exp_t e;
            e.wr = 16'h0; e.st = 1'b1; e.mx = 3'd0; e.op = 4'd0; e.cd = 32'h0;
            begin_session(0);
            chk("zero_start_t1", 64'(start_exec), 64'h0);
            chk("zero_busy", 64'(busy), 64'h1);
            q.push_back(e);
            tick();
            chk("zero_start_t2", 64'(start_exec), 64'h1);
            end_session(1'b0, 0);
        end

        // All-ones PE id: broadcast or drop depending on build.
        begin_session(1);
        send(31, 4, 12, 32'hDEAD_BEEF, BC_WR, 1'b1, BC_MAX);
        end_session(BC_ERR, BC_MAX);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/elastic_config_loader.md
# elastic_config_loader

Sequential configuration loader sitting directly upstream of every elastic PE's config-load and execution-parameter interface. It accepts configuration records over a SELF-protocol (valid/stop) stream and converts each one into a one-cycle, PE-selective config write. It also tracks the highest context index written to form `mapping_context_max_id`, then issues a single `start_exec` pulse to all PEs once the programmed record count has been written.

## Interface
Parameters:
- PE_NUM, 16, number of PEs driven; one write-enable bit per PE
- PE_ID_WIDTH, 5, width of record PE id; must satisfy 2^PE_ID_WIDTH > PE_NUM
- CONTEXT_SIZE, 8, config contexts per PE
- CONTEXT_SIZE_BIT_LENGTH, 3, width of context index
- INPUT_NUM_BIT_LENGTH, 3, width of mux select fields
- NEIGHBOR_PE_NUM, 4, width of output-enable mask
- OPERATION_BIT_LENGTH, 4, opcode width
- DATA_WIDTH, 32, const-data width
- COUNT_WIDTH, 16, width of record count

Ports (reset reset_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- load_start  in  1  pulse: begin load session; ignored unless IDLE
- load_abort  in  1  pulse: abandon session, no start_exec
- load_entry_count  in  COUNT_WIDTH  records in session, sampled on load_start
- cfg_valid  in  1  record valid
- cfg_stop  out  1  backpressure to record source
- cfg_pe_id  in  PE_ID_WIDTH  target PE
- cfg_context_index  in  CONTEXT_SIZE_BIT_LENGTH  target context
- cfg_input_index_1 / cfg_input_index_2  in  INPUT_NUM_BIT_LENGTH  mux selects
- cfg_output_mask  in  NEIGHBOR_PE_NUM  output-enable mask
- cfg_op  in  OPERATION_BIT_LENGTH  opcode
- cfg_const_data  in  DATA_WIDTH  constant
- config_input_PE_index_1/2, config_output_PE_index, config_op, config_const_data, config_index  out  matching widths  registered record fields, shared by all PEs
- write_config_data  out  PE_NUM  per-PE write enable
- mapping_context_max_id  out  CONTEXT_SIZE_BIT_LENGTH  highest context written in the session
- start_exec  out  1  one-cycle pulse to all PEs
- busy  out  1  high in LOAD/START
- done  out  1  sticky: session completed, cleared by next load_start
- error  out  1  sticky: record dropped, cleared by next load_start

## Operation
- FSM states: IDLE, LOAD, START.
- IDLE:
  - cfg_stop=1.
  - On load_start: remaining=load_entry_count, max_id=0, done=0, error=0.
  - Then → LOAD if count≠0, else → START.
- LOAD:
  - cfg_stop=0.
  - Record accepted when cfg_valid && !cfg_stop; remaining decrements by one per accept.
  - On an accepted record, all config_* outputs register the record fields.
  - write_config_data = one-hot(cfg_pe_id) for one cycle.
  - max_id = max(max_id, cfg_context_index).
  - Record dropped (write_config_data stays 0, max_id unchanged, error set, still counted) if cfg_pe_id ≥ PE_NUM or cfg_context_index ≥ CONTEXT_SIZE.
  - After the accept that brings remaining to 0: cfg_stop=1 from the next cycle, → START.
- START:
  - start_exec=1 for exactly one cycle.
  - mapping_context_max_id=max_id, held until the next session's START.
  - done=1, → IDLE.
- load_abort, in LOAD or START: → IDLE next cycle.
  - No start_exec; done stays 0.
  - A record accepted in the abort cycle is still written.
- A load_start pulse arriving outside IDLE is ignored.

## Timing
- Reset values: all config_* outputs 0, write_config_data 0, mapping_context_max_id 0, start_exec 0, busy 0, done 0, error 0, cfg_stop 1, FSM IDLE.
- Reset mid-session returns to IDLE with no further writes.
- load_start at cycle T: cfg_stop=0 at T+1.
- Record accepted at cycle N: write pulse and config_* fields valid at N+1.
- Throughput: 1 record/cycle.
- Last record accepted at N: write at N+1, start_exec at N+1 together with that write (PEs see the final write and start in the same edge).
- Zero-count session: start_exec at T+2.
- Record and start paths:
  - cfg_stop is purely a function of the FSM state, with no combinational path from cfg_valid.
  - start_exec pulses exactly once per completed session.

## Configuration
- CONFIG_LOADER_BROADCAST_EN defined:
  - cfg_pe_id all-ones is a broadcast: write_config_data = all PE_NUM bits set for that record.
  - Not flagged as an error.
- CONFIG_LOADER_BROADCAST_EN undefined:
  - All-ones id is an ordinary out-of-range id.
  - The record is dropped and error is set.

## Test plan
- Reset, then load_start with count=3 and records (pe 0, ctx 0), (pe 5, ctx 2), (pe 15, ctx 1) on consecutive cycles → write_config_data 0x0001, 0x0020, 0x8000 on consecutive cycles; start_exec with the last write; mapping_context_max_id=2; done=1.
- cfg_valid toggling 1/0 every cycle, count=4 → exactly 4 write pulses; start_exec once; no write while cfg_valid=0.
- Records with pe_id=16 and ctx=9, count=2 → no write pulses; error=1; start_exec still pulses; mapping_context_max_id=0.
- load_abort after 2 of 5 records → 2 writes; cfg_stop=1 next cycle; no start_exec; done=0.
- load_entry_count=0 → start_exec exactly 2 cycles after load_start.
- With CONFIG_LOADER_BROADCAST_EN, pe_id=31 → write_config_data=0xFFFF and error=0.
- Without CONFIG_LOADER_BROADCAST_EN, pe_id=31 → write_config_data=0 and error=1.
